// File: rtl/score_tracker_pkg.sv
// Constants shared by score_tracker and the display blocks: game states and default limits.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RESPAWN = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  localparam int DEF_SCORE_MAX   = 99;
  localparam int DEF_START_LIVES = 3;

  // Bits needed to hold the points of every channel hitting in the same cycle.
  function automatic int pts_width(input int n_hit, input int pts_unit);
    return $clog2(n_hit * (n_hit + 1) / 2 * pts_unit + 1);
  endfunction

endpackage

// File: rtl/score_tracker_hit_point_sum.sv
// Sums the points of all asserted hit channels and saturates score+pts at SCORE_MAX.
// Latency: combinational; no backpressure.
module hit_point_sum
  import score_tracker_pkg::*;
#(
  parameter int N_HIT     = 4,
  parameter int PTS_UNIT  = 1,
  parameter int SCORE_W   = 7,
  parameter int SCORE_MAX = DEF_SCORE_MAX,
  parameter int PTS_W     = pts_width(N_HIT, PTS_UNIT)
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [N_HIT-1:0]   invader_hit,
  output logic [PTS_W-1:0]   pts,
  output logic [SCORE_W-1:0] new_score
);

  logic [31:0] acc;
  logic [31:0] sum;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_HIT; i++) begin
      if (invader_hit[i]) acc = acc + 32'((i + 1) * PTS_UNIT);
    end
    sum       = acc + 32'(score);
    pts       = PTS_W'(acc);
    new_score = (sum > 32'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
  end

endmodule

// File: rtl/score_tracker.sv
// Score, lives, extra-life bonus and invulnerability tracking with the game-state FSM.
// Latency: 1 cycle from any input pulse to registered outputs; no backpressure.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int N_HIT         = 4,
  parameter int PTS_UNIT      = 1,
  parameter int SCORE_W       = 7,
  parameter int SCORE_MAX     = DEF_SCORE_MAX,
  parameter int LIVES_W       = 2,
  parameter int START_LIVES   = DEF_START_LIVES,
  parameter int BONUS_STEP    = 50,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               frame_tick,
  input  logic               game_start,
  input  logic [N_HIT-1:0]   invader_hit,
  input  logic               player_hit,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [1:0]         state,
  output logic               invuln,
  output logic               bonus,
  output logic               game_over
);

  localparam int PTS_W = pts_width(N_HIT, PTS_UNIT);
  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam int NB_W  = $clog2(SCORE_MAX + BONUS_STEP + 1);

  game_state_t        state_q;
  logic [CNT_W-1:0]   inv_cnt;
  logic [NB_W-1:0]    next_bonus;
  logic [PTS_W-1:0]   pts;
  logic [SCORE_W-1:0] new_score;
  logic               bonus_hit;
  logic [LIVES_W-1:0] lives_tmp;

  hit_point_sum #(
    .N_HIT    (N_HIT),
    .PTS_UNIT (PTS_UNIT),
    .SCORE_W  (SCORE_W),
    .SCORE_MAX(SCORE_MAX),
    .PTS_W    (PTS_W)
  ) u_hit_point_sum (
    .score      (score),
    .invader_hit(invader_hit),
    .pts        (pts),
    .new_score  (new_score)
  );

  // Once next_bonus has moved past SCORE_MAX no further bonus can ever fire.
  always_comb begin
    bonus_hit = (32'(new_score) >= 32'(next_bonus)) && (32'(next_bonus) <= 32'(SCORE_MAX));
    lives_tmp = lives;
    if (bonus_hit && (lives != '1)) lives_tmp = lives + LIVES_W'(1);
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= ST_IDLE;
      score      <= '0;
      lives      <= '0;
      next_bonus <= NB_W'(BONUS_STEP);
      inv_cnt    <= '0;
      invuln     <= 1'b0;
      bonus      <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      bonus <= 1'b0;
      if (game_start) begin
        state_q    <= ST_PLAY;
        score      <= '0;
        lives      <= LIVES_W'(START_LIVES);
        next_bonus <= NB_W'(BONUS_STEP);
        inv_cnt    <= '0;
        invuln     <= 1'b0;
        game_over  <= 1'b0;
      end else begin
        case (state_q)
          ST_PLAY, ST_RESPAWN: begin
            if (pts != '0) score <= new_score;
            if (bonus_hit) begin
              bonus      <= 1'b1;
              next_bonus <= next_bonus + NB_W'(BONUS_STEP);
            end
            // The player hit is applied on top of any life just awarded this cycle.
            if ((state_q == ST_PLAY) && player_hit) begin
              lives <= lives_tmp - LIVES_W'(1);
              if (lives_tmp == LIVES_W'(1)) begin
                state_q   <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state_q <= ST_RESPAWN;
                inv_cnt <= CNT_W'(INVULN_FRAMES);
                invuln  <= 1'b1;
              end
            end else begin
              lives <= lives_tmp;
              if ((state_q == ST_RESPAWN) && frame_tick) begin
                inv_cnt <= inv_cnt - CNT_W'(1);
                if (inv_cnt == CNT_W'(1)) begin
                  state_q <= ST_PLAY;
                  invuln  <= 1'b0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
